// File: rtl/uart_sram_loader_if.sv
// Receiver handshake and SRAM write port between uart_sram_loader and its neighbours.
// The loader drives through the master modport.
interface uart_sram_loader_if #(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic [7:0]            RX_data;
    logic                  RX_empty;
    logic                  RX_unload;
    logic                  RX_enable;
    logic [ADDR_WIDTH-1:0] SRAM_address;
    logic [DATA_WIDTH-1:0] SRAM_write_data;
    logic                  SRAM_we_n;

    modport master (
        input  RX_data, RX_empty,
        output RX_unload, RX_enable, SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport slave (
        output RX_data, RX_empty,
        input  RX_unload, RX_enable, SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/uart_sram_loader.sv
// Pulls bytes from the UART receiver, skips optional newline-terminated header lines,
// packs them into SRAM words and writes them across a programmable address window.
module uart_sram_loader #(
    parameter int unsigned ADDR_WIDTH    = 18,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned HEADER_LINES  = 0,
    parameter int unsigned LITTLE_ENDIAN = 0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Initialize,
    input  logic                  Enable,
    input  logic [ADDR_WIDTH-1:0] Start_address,
    input  logic [ADDR_WIDTH-1:0] Last_address,
    output logic                  Busy,
    output logic                  Done,
    output logic [ADDR_WIDTH:0]   Word_count,
    uart_sram_loader_if.master    bus
);
    localparam int unsigned BYTES  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned LINE_W = 4;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BYTES - 1);
    localparam logic [LINE_W-1:0] HDR_TARGET = LINE_W'(HEADER_LINES);

    typedef enum logic [2:0] {
        IDLE, HDR_WAIT, HDR_ACK, BYTE_WAIT, BYTE_ACK, WRITE, FINISH
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [IDX_W-1:0]      idx;
    logic [LINE_W-1:0]     line_cnt;
    logic [IDX_W-1:0]      lane;

    // Byte lane for the current byte position within the word
    assign lane = (LITTLE_ENDIAN != 0) ? idx : LAST_IDX - idx;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state               <= IDLE;
            last_addr           <= '0;
            idx                 <= '0;
            line_cnt            <= '0;
            bus.SRAM_we_n       <= 1'b1;
            bus.SRAM_address    <= '0;
            bus.SRAM_write_data <= '0;
            bus.RX_unload       <= 1'b0;
            bus.RX_enable       <= 1'b0;
            Busy                <= 1'b0;
            Done                <= 1'b0;
            Word_count          <= '0;
        end else if (Initialize) begin
            // Abort keeps the last address so the SRAM side sees no spurious jump
            state               <= IDLE;
            idx                 <= '0;
            line_cnt            <= '0;
            bus.SRAM_we_n       <= 1'b1;
            bus.SRAM_write_data <= '0;
            bus.RX_unload       <= 1'b0;
            bus.RX_enable       <= 1'b0;
            Busy                <= 1'b0;
            Done                <= 1'b0;
            Word_count          <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Enable) begin
                        last_addr        <= Last_address;
                        bus.SRAM_address <= Start_address;
                        Word_count       <= '0;
                        bus.RX_enable    <= 1'b1;
                        Busy             <= 1'b1;
                        idx              <= '0;
                        line_cnt         <= '0;
                        state            <= (HEADER_LINES > 0) ? HDR_WAIT : BYTE_WAIT;
                    end
                end
                HDR_WAIT: begin
                    if (!bus.RX_empty) begin
                        bus.RX_unload <= 1'b1;
                        if (bus.RX_data == 8'h0A) line_cnt <= line_cnt + 1'b1;
                        state <= HDR_ACK;
                    end
                end
                HDR_ACK: begin
                    if (bus.RX_empty) begin
                        bus.RX_unload <= 1'b0;
                        state <= (line_cnt == HDR_TARGET) ? BYTE_WAIT : HDR_WAIT;
                    end
                end
                BYTE_WAIT: begin
                    if (!bus.RX_empty) begin
                        bus.RX_unload <= 1'b1;
                        for (int unsigned b = 0; b < BYTES; b++) begin
                            if (lane == IDX_W'(b)) bus.SRAM_write_data[8*b +: 8] <= bus.RX_data;
                        end
                        state <= BYTE_ACK;
                    end
                end
                BYTE_ACK: begin
                    if (bus.RX_empty) begin
                        bus.RX_unload <= 1'b0;
                        if (idx == LAST_IDX) begin
                            idx           <= '0;
                            bus.SRAM_we_n <= 1'b0;
                            state         <= WRITE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= BYTE_WAIT;
                        end
                    end
                end
                WRITE: begin
                    bus.SRAM_we_n <= 1'b1;
                    Word_count    <= Word_count + 1'b1;
                    if (bus.SRAM_address == last_addr) begin
                        Done          <= 1'b1;
                        Busy          <= 1'b0;
                        bus.RX_enable <= 1'b0;
                        state         <= FINISH;
                    end else begin
                        bus.SRAM_address <= bus.SRAM_address + 1'b1;
                        state            <= BYTE_WAIT;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_sram_loader.sv
// Three loader configurations driven by a randomized receiver model; expected SRAM
// writes come from a byte-stream reference model and are checked by per-config monitors.
module tb_uart_sram_loader;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    function automatic int unsigned aw_of(input int i);
        return (i == 1) ? 4 : 18;
    endfunction
    function automatic int unsigned dw_of(input int i);
        return (i == 1) ? 32 : 16;
    endfunction
    function automatic int unsigned hl_of(input int i);
        return (i == 2) ? 3 : 0;
    endfunction
    function automatic int unsigned le_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    logic        clk;
    logic        rst;
    logic [2:0]  en;
    logic [2:0]  init;
    logic [2:0]  flush;
    logic [31:0] start_a [3];
    logic [31:0] last_a  [3];

    logic [2:0]  busy_w, done_w, we_w, unload_w, rxen_w;
    logic [31:0] addr_w [3];
    logic [31:0] data_w [3];
    logic [31:0] wc_w   [3];
    int          done_cnt [3];

    logic [7:0]  rxq  [3][$];
    wr_t         expq [3][$];

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input int i, input logic [31:0] got,
                                input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cfg%0d got=%0h exp=%0h", name, i, got, exp);
        end
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int unsigned AW = aw_of(g);
        localparam int unsigned DW = dw_of(g);
        logic [AW:0] wc;

        uart_sram_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

        uart_sram_loader #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
            .HEADER_LINES(hl_of(g)), .LITTLE_ENDIAN(le_of(g))
        ) dut (
            .Clock(clk),
            .Reset(rst),
            .Initialize(init[g]),
            .Enable(en[g]),
            .Start_address(AW'(start_a[g])),
            .Last_address(AW'(last_a[g])),
            .Busy(busy_w[g]),
            .Done(done_w[g]),
            .Word_count(wc),
            .bus(bus)
        );

        assign we_w[g]     = bus.SRAM_we_n;
        assign unload_w[g] = bus.RX_unload;
        assign rxen_w[g]   = bus.RX_enable;
        assign addr_w[g]   = 32'(bus.SRAM_address);
        assign data_w[g]   = 32'(bus.SRAM_write_data);
        assign wc_w[g]     = 32'(wc);

        // Receiver: offers queued bytes with random gaps, drops each one once unloaded
        initial begin
            bus.RX_empty = 1'b1;
            bus.RX_data  = 8'h00;
            forever begin
                @(posedge clk);
                #1;
                if (flush[g]) begin
                    rxq[g].delete();
                    bus.RX_empty = 1'b1;
                end else if (bus.RX_empty) begin
                    if (!bus.RX_unload && rxq[g].size() > 0 && $urandom_range(0, 3) != 0) begin
                        bus.RX_data  = rxq[g].pop_front();
                        bus.RX_empty = 1'b0;
                    end
                end else if (bus.RX_unload) begin
                    bus.RX_empty = 1'b1;
                end
            end
        end

        always @(negedge clk) begin : mon
            wr_t e;
            if (!rst && bus.SRAM_we_n === 1'b0) begin
                if (expq[g].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write cfg%0d addr=%0h data=%0h", g,
                             addr_w[g], data_w[g]);
                end else begin
                    e = expq[g].pop_front();
                    chk("write_addr", g, addr_w[g], e.addr);
                    chk("write_data", g, data_w[g], e.data);
                end
            end
        end

        always @(negedge clk) if (done_w[g]) done_cnt[g] <= done_cnt[g] + 1;
    end

    // Reference model: strip header lines, pack bytes, queue expected writes, then start
    task automatic launch(input int i, input int st, input int la, input logic [7:0] s[$],
                          output int n);
        int mask  = (1 << aw_of(i)) - 1;
        int nb    = int'(dw_of(i) / 8);
        int k     = 0;
        int lines = 0;
        wr_t e;
        while (lines < int'(hl_of(i))) begin
            if (s[k] == 8'h0A) lines++;
            k++;
        end
        n = ((la - st) & mask) + 1;
        for (int w = 0; w < n; w++) begin
            e.data = '0;
            for (int b = 0; b < nb; b++) begin
                if (le_of(i) != 0) e.data[8*b +: 8] = s[k];
                else               e.data[8*(nb-1-b) +: 8] = s[k];
                k++;
            end
            e.addr = 32'((st + w) & mask);
            expq[i].push_back(e);
        end
        foreach (s[j]) rxq[i].push_back(s[j]);
        start_a[i] = 32'(st);
        last_a[i]  = 32'(la);
        @(posedge clk);
        #1 en[i] = 1'b1;
        @(posedge clk);
        #1 en[i] = 1'b0;
        chk("busy_after_enable", i, 32'(busy_w[i]), 32'd1);
    endtask

    task automatic wait_done(input int i, input int n, input int la, input int dc0);
        int t = 0;
        while (!done_w[i] && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!done_w[i]) begin
            checks++;
            failures++;
            $display("FAIL done_timeout cfg%0d got=0 exp=1", i);
        end else begin
            chk("word_count", i, wc_w[i], 32'(n));
            chk("busy_at_done", i, 32'(busy_w[i]), 32'd0);
            chk("rx_enable_at_done", i, 32'(rxen_w[i]), 32'd0);
            chk("addr_at_done", i, addr_w[i], 32'(la));
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", i, 32'(done_cnt[i] - dc0), 32'd1);
        chk("writes_pending", i, 32'(expq[i].size()), 32'd0);
    endtask

    task automatic xfer(input int i, input int st, input int la, input logic [7:0] s[$]);
        int n;
        int dc0 = done_cnt[i];
        launch(i, st, la, s, n);
        wait_done(i, n, la & ((1 << aw_of(i)) - 1), dc0);
    endtask

    task automatic do_flush();
        flush = 3'b111;
        repeat (2) @(posedge clk);
        #1 flush = 3'b000;
    endtask

    initial begin : main
        logic [7:0] s[$];
        string      hdr;
        int         n, t;

        rst = 1'b1; en = '0; init = '0; flush = '0;
        for (int i = 0; i < 3; i++) begin
            start_a[i] = '0;
            last_a[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_we_n", i, 32'(we_w[i]), 32'd1);
            chk("reset_addr", i, addr_w[i], 32'd0);
            chk("reset_busy", i, 32'(busy_w[i]), 32'd0);
            chk("reset_unload", i, 32'(unload_w[i]), 32'd0);
            chk("reset_wc", i, wc_w[i], 32'd0);
        end
        rst = 1'b0;

        s = {8'h12, 8'h34, 8'h56, 8'h78};
        xfer(0, 76800, 76801, s);

        s = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        xfer(1, 5, 5, s);

        hdr = "P6\n320 240\n255\n";
        s.delete();
        for (int c = 0; c < hdr.len(); c++) s.push_back(hdr[c]);
        s.push_back(8'h0A);
        s.push_back(8'h01);
        xfer(2, 500, 500, s);

        s.delete();
        for (int c = 0; c < 16; c++) s.push_back(8'(c * 17 + 3));
        xfer(1, 14, 1, s);

        // Abort after one byte of a word, then restart cleanly
        s.delete();
        for (int c = 0; c < 8; c++) s.push_back(8'($urandom_range(0, 255)));
        foreach (s[j]) rxq[1].push_back(s[j]);
        start_a[1] = 32'd3;
        last_a[1]  = 32'd4;
        @(posedge clk);
        #1 en[1] = 1'b1;
        @(posedge clk);
        #1 en[1] = 1'b0;
        t = 0;
        while (unload_w[1] !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("first_byte_unload", 1, 32'(unload_w[1]), 32'd1);
        init[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("init_busy", 1, 32'(busy_w[1]), 32'd0);
        chk("init_unload", 1, 32'(unload_w[1]), 32'd0);
        chk("init_rx_enable", 1, 32'(rxen_w[1]), 32'd0);
        chk("init_we_n", 1, 32'(we_w[1]), 32'd1);
        chk("init_addr_kept", 1, addr_w[1], 32'd3);
        en[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("init_beats_enable", 1, 32'(busy_w[1]), 32'd0);
        init[1] = 1'b0;
        en[1]   = 1'b0;
        do_flush();
        s.delete();
        for (int c = 0; c < 8; c++) s.push_back(8'($urandom_range(0, 255)));
        xfer(1, 7, 8, s);

        // Randomized windows and byte streams on every configuration
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 5; r++) begin
                int st, la, nw;
                int mask = (1 << aw_of(i)) - 1;
                nw = int'($urandom_range(1, 4));
                if (aw_of(i) == 4) st = int'($urandom_range(0, 15));
                else if ($urandom_range(0, 1) == 1) st = 262144 - int'($urandom_range(1, 3));
                else st = int'($urandom_range(0, 262143));
                la = (st + nw - 1) & mask;
                s.delete();
                for (int l = 0; l < int'(hl_of(i)); l++) begin
                    int len = int'($urandom_range(0, 3));
                    for (int c = 0; c < len; c++) s.push_back(8'($urandom_range(32, 126)));
                    s.push_back(8'h0A);
                end
                for (int c = 0; c < nw * int'(dw_of(i) / 8); c++)
                    s.push_back(($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom_range(0, 255)));
                xfer(i, st, la, s);
            end
        end

        // Reset landing on a write cycle
        s.delete();
        for (int c = 0; c < 8; c++) s.push_back(8'($urandom_range(0, 255)));
        launch(0, 100, 103, s, n);
        t = 0;
        while (we_w[0] !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("write_seen_before_reset", 0, 32'(we_w[0]), 32'd0);
        #1;
        rst   = 1'b1;
        en[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_we_n", 0, 32'(we_w[0]), 32'd1);
        chk("rst_addr", 0, addr_w[0], 32'd0);
        chk("rst_data", 0, data_w[0], 32'd0);
        chk("rst_unload", 0, 32'(unload_w[0]), 32'd0);
        chk("rst_rx_enable", 0, 32'(rxen_w[0]), 32'd0);
        chk("rst_busy", 0, 32'(busy_w[0]), 32'd0);
        chk("rst_done", 0, 32'(done_w[0]), 32'd0);
        chk("rst_wc", 0, wc_w[0], 32'd0);
        @(posedge clk);
        #1;
        chk("rst_ignores_enable", 0, 32'(busy_w[0]), 32'd0);
        rst   = 1'b0;
        en[0] = 1'b0;
        do_flush();
        expq[0].delete();
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
